// File: rtl/adc_sample_src_pkg.sv
// adc_sample_src_pkg: shared types, frame constants and parameter sanity checks for the ADC sample source.
package adc_sample_src_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_e;

    localparam int FRAME_BITS = 16;
    localparam int SAMPLE_W   = 16;

    function automatic bit frame_fits(input int lead_bits, input int adc_bits);
        return adc_bits >= 2 && adc_bits <= SAMPLE_W && lead_bits >= 0 && lead_bits + adc_bits <= FRAME_BITS;
    endfunction

    function automatic bit clk_div_ok(input int clk_div);
        return clk_div >= 2;
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// adc_tick_gen: sample-rate counter; held at zero while disabled, registered one-cycle tick once per period.
module adc_tick_gen #(
    parameter int PERIOD = 12500
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last  = cnt_q == CW'(PERIOD - 1);
    assign cnt_d = (!en_i || last) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_o <= en_i && last;
        end
    end

endmodule

// File: rtl/adc_sample_src.sv
// adc_sample_src: one SPI read frame per sample tick on a serial unipolar ADC,
// delivering the code as a left-justified signed 16-bit sample with a one-cycle strobe.
module adc_sample_src
    import adc_sample_src_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 12500,
    parameter int ADC_BITS      = 12,
    parameter int LEAD_BITS     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                adc_sdo,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [SAMPLE_W-1:0] dout,
    output logic                out_en,
    output logic                overrun
);

    if (!(frame_fits(LEAD_BITS, ADC_BITS) && clk_div_ok(CLK_DIV))) begin : g_bad_cfg
        $error("adc_sample_src: illegal CLK_DIV/ADC_BITS/LEAD_BITS combination");
    end

    localparam int DW   = $clog2(CLK_DIV);
    localparam int BW   = $clog2(FRAME_BITS);
    // Leading bits shift out of the top of this register and are never stored.
    localparam int KEEP = FRAME_BITS - LEAD_BITS;
    localparam logic [ADC_BITS-1:0] SIGN = ADC_BITS'(1) << (ADC_BITS - 1);

    state_e              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                hi_q, hi_d;
    logic [KEEP-1:0]     shift_q, shift_d;
    logic                cs_n_q, cs_n_d, sclk_q, sclk_d, out_en_q, out_en_d, overrun_q, overrun_d;
    logic [SAMPLE_W-1:0] dout_q, dout_d;
    logic                tick, div_end;
    logic [ADC_BITS-1:0] code;
    logic [SAMPLE_W-1:0] sample;

    adc_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (en),
        .tick_o (tick)
    );

    // Offset binary to two's complement: flip the MSB, then left-justify.
    assign code   = shift_q[KEEP-1 -: ADC_BITS];
    assign sample = SAMPLE_W'({code ^ SIGN, {SAMPLE_W{1'b0}}} >> ADC_BITS);

    always_comb begin
        div_end = div_q == DW'(CLK_DIV - 1);
        state_d = state_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        shift_d = shift_q;
        div_d   = ((state_q == SETUP || state_q == SHIFT) && !div_end) ? div_q + DW'(1) : '0;
        unique case (state_q)
            IDLE:  if (tick) state_d = SETUP;
            SETUP: if (div_end) state_d = SHIFT;
            SHIFT: if (div_end) begin
                hi_d = !hi_q;
                if (!hi_q) shift_d = {shift_q[KEEP-2:0], adc_sdo};
                else begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(FRAME_BITS - 1)) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so the pins change with the state.
        cs_n_d    = !(state_d == SETUP || state_d == SHIFT);
        sclk_d    = !(state_d == SHIFT && !hi_d);
        out_en_d  = state_d == DONE;
        dout_d    = (state_d == DONE) ? sample : dout_q;
        overrun_d = overrun_q || (tick && state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            hi_q      <= 1'b0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            out_en_q  <= 1'b0;
            overrun_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            hi_q      <= hi_d;
            shift_q   <= shift_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            out_en_q  <= out_en_d;
            overrun_q <= overrun_d;
            dout_q    <= dout_d;
        end
    end

    assign adc_cs_n = cs_n_q;
    assign adc_sclk = sclk_q;
    assign out_en   = out_en_q;
    assign overrun  = overrun_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_adc_sample_src.sv
// tb_adc_sample_src: two instances (sample period 200 and 100) driven by behavioural ADC models,
// directed timing steps plus random codes checked against a signed-arithmetic reference.
module tb_adc_sample_src;

    localparam int CLK_DIV   = 4;
    localparam int ADC_BITS  = 12;
    localparam int LEAD_BITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [1:0]  cs_n, sclk, out_en, overrun;
    logic [15:0] dout [2];
    logic [11:0] forced [$] = '{12'h800, 12'hFFF, 12'h000, 12'h801};
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        sdo_l = 1'b0;
        logic [15:0] word = '0;
        logic [11:0] code;
        logic [15:0] exp_q [$];
        int          nbit = 0, rises = 0, low_cyc = 0;
        logic        prev_en = 1'b0;

        adc_sample_src #(
            .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(g == 0 ? 200 : 100),
            .ADC_BITS(ADC_BITS), .LEAD_BITS(LEAD_BITS)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .adc_sdo(sdo_l),
            .adc_cs_n(cs_n[g]), .adc_sclk(sclk[g]), .dout(dout[g]),
            .out_en(out_en[g]), .overrun(overrun[g])
        );

        // ADC model: new frame on CS fall, junk leading bits, one bit after each SCLK fall
        always @(negedge cs_n[g]) begin
            if (g == 0 && forced.size() > 0) code = forced.pop_front();
            else code = 12'($urandom);
            word = {4'($urandom), code};
            exp_q.push_back(16'((int'(code) - 2048) * 16));
            nbit = 0;
            rises = 0;
            low_cyc = 0;
        end

        always @(negedge sclk[g]) if (!cs_n[g] && nbit < 16) begin
            #2;
            sdo_l = word[15 - nbit];
            nbit++;
        end

        always @(posedge sclk[g]) if (!cs_n[g] && rst) rises++;

        always @(negedge rst) exp_q.delete();

        always @(negedge clk) begin
            if (!cs_n[g]) low_cyc++;
            if (rst && out_en[g]) begin
                chk($sformatf("pending%0d", g), exp_q.size(), 1);
                if (exp_q.size() > 0) chk($sformatf("dout_model%0d", g), dout[g], exp_q.pop_front());
                chk($sformatf("sclk_rises%0d", g), rises, 16);
                chk($sformatf("cs_low_cycles%0d", g), low_cyc, 132);
                chk($sformatf("strobe_width%0d", g), prev_en, 0);
            end
            prev_en = out_en[g];
        end
    end

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_en[0] && n < 1000);
    endtask

    initial begin
        int n, act;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 2'b11);
        chk("rst_sclk", sclk, 2'b11);
        chk("rst_out_en", out_en, 2'b00);
        chk("rst_overrun", overrun, 2'b00);
        chk("rst_dout0", dout[0], 16'h0000);
        chk("rst_dout1", dout[1], 16'h0000);
        rst = 1'b1;
        en  = 1'b1;
        wait_out(n);
        chk("first_latency", n, 333);
        chk("dout_800", dout[0], 16'h0000);
        chk("overrun_slow", overrun[0], 1'b0);
        chk("overrun_fast", overrun[1], 1'b1);
        wait_out(n);
        chk("gap_fff", n, 200);
        chk("dout_fff", dout[0], 16'h7FF0);
        wait_out(n);
        chk("gap_000", n, 200);
        chk("dout_000", dout[0], 16'h8000);
        wait_out(n);
        chk("gap_801", n, 200);
        chk("dout_801", dout[0], 16'h0010);
        repeat (3) begin
            wait_out(n);
            chk("gap_random", n, 200);
        end
        repeat (107) @(posedge clk);
        #1 en = 1'b0;
        wait_out(n);
        chk("en_drop_frame", n, 93);
        act = 0;
        repeat (600) begin
            @(posedge clk);
            #1;
            act += int'(!cs_n[0]) + int'(out_en[0]);
        end
        chk("quiet_after_en_drop", act, 0);
        en = 1'b1;
        wait_out(n);
        chk("reenable_latency", n, 333);
        repeat (107) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_cs_n", cs_n, 2'b11);
        chk("arst_sclk", sclk, 2'b11);
        chk("arst_dout", dout[0], 16'h0000);
        chk("arst_out_en", out_en[0], 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_out(n);
        chk("post_reset_latency", n, 333);
        wait_out(n);
        chk("post_reset_gap", n, 200);
        chk("overrun_slow_end", overrun[0], 1'b0);
        chk("overrun_fast_end", overrun[1], 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sample_src.md
Name: adc_sample_src

Overview:
Front-end sample source for the mosquito detection chain: the producer side of the din/in_en sample interface that feeds the FIR.
- Generates a fixed sample-rate tick.
- Runs one SPI-style read frame per tick on a serial unipolar ADC (CS_n/SCLK/SDO).
- Converts the code to left-justified signed 16-bit.
- Presents it as dout with a one-cycle out_en strobe.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
SAMPLE_PERIOD, 12500, clk cycles per sample tick (4 kHz at 50 MHz)
ADC_BITS, 12, ADC resolution (<=16)
LEAD_BITS, 4, leading null bits in each 16-bit frame before data MSB (LEAD_BITS+ADC_BITS<=16)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
en  input  1  run enable
adc_sdo  input  1  ADC serial data, MSB first, changes after SCLK falling edge
adc_cs_n  output  1  ADC chip select, active-low
adc_sclk  output  1  ADC serial clock, idles high
dout  output  16  signed two's-complement sample, left-justified (drives FIR din)
out_en  output  1  one-cycle strobe, dout valid (drives FIR in_en)
overrun  output  1  sticky: tick arrived while a frame was in progress

Behaviour:
- Reset (rst=0, async): state IDLE, tick counter 0, adc_cs_n=1, adc_sclk=1, dout=0, out_en=0, overrun=0. Reset mid-frame aborts the frame immediately, with no out_en.
- Tick counter: counts 0..SAMPLE_PERIOD-1 while en=1 and pulses tick when count==SAMPLE_PERIOD-1. While en=0, the counter is held at 0.
- States:
  - IDLE: cs_n=1, sclk=1. On tick, go to SETUP.
  - SETUP: cs_n=0, sclk=1 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 bit periods. Each period is sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles. adc_sdo is captured into a 16-bit shift register (MSB first) at the clk edge ending each low phase, i.e. the edge where adc_sclk rises. After the 16th high phase, go to DONE.
  - DONE (1 cycle): cs_n=1, dout updated, out_en=1. Then go to IDLE.
- Latency: out_en is high in cycle 33*CLK_DIV+1 after the tick cycle (133 at CLK_DIV=4).
- Data extraction: code = shift[15-LEAD_BITS -: ADC_BITS]. Leading and trailing bits are ignored.
- Conversion: dout = (code XOR 2^(ADC_BITS-1)) << (16-ADC_BITS). The low bits are zero.
- dout holds its value between strobes. out_en is never high for 2 consecutive cycles.
- Tick while not IDLE: the tick is dropped, overrun is set to 1 and stays set until reset. The frame in progress continues unaffected.
- en falling mid-frame: the frame completes and delivers its out_en, then no further frames start. en rising: the first frame starts SAMPLE_PERIOD cycles later.
- All outputs are registered; no combinational path from adc_sdo to any output.

Decomposition:
- Shared package:
  - state enum (IDLE, SETUP, SHIFT, DONE)
  - FRAME_BITS=16
  - sample width 16
  - compile-time check functions for the LEAD_BITS+ADC_BITS and CLK_DIV constraints
- Sub-module: adc_tick_gen, a sample-rate counter with en hold and tick output. It is reused later for the LED/report timing.

Test Plan:
- Common bench setup: CLK_DIV=4, ADC_BITS=12, LEAD_BITS=4, with a behavioural ADC model.
- Model returns code 0x800 -> out_en single pulse 133 cycles after tick; dout=0x0000; exactly 16 adc_sclk rising edges with adc_cs_n low throughout.
- Codes 0xFFF, 0x000, 0x801 over successive frames -> dout 0x7FF0, 0x8000, 0x0010 respectively.
- SAMPLE_PERIOD=200, en held 1 -> out_en pulses exactly 200 cycles apart; adc_cs_n low 132 cycles per frame; overrun stays 0.
- en dropped during SHIFT -> that frame still yields one out_en; no further adc_cs_n activity. Re-raise en -> next out_en at 200+133 cycles.
- rst pulled low mid-SHIFT -> adc_cs_n=1, adc_sclk=1, dout=0 in the same cycle. No out_en for the aborted frame. Normal frames resume one period after release.
- SAMPLE_PERIOD=100 (< frame length) -> overrun rises at the first tick during a frame and stays 1; delivered samples are still correct.
